// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch trace driver.
// Trace records pair a branch PC with its resolved outcome.
package branch_pkg;

  localparam int PC_NBITS = 32;

  typedef struct packed {
    logic [PC_NBITS-1:0] pc;
    logic                taken;
  } trace_rec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRED = 2'd1,
    UPD  = 2'd2
  } drv_state_e;

  // Increment that sticks at the all-ones value of an nbits-wide counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned nbits);
    logic [63:0] max_val;
    max_val = (nbits >= 64) ? '1 : ((64'd1 << nbits) - 64'd1);
    return (val >= max_val) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/vc_Regfile_1r1w.sv
// Register file with one combinational read port and one synchronous write port.
// Contents are deliberately not reset.
module vc_Regfile_1r1w #(
  parameter int p_data_nbits  = 1,
  parameter int p_num_entries = 2
) (
  input  logic                             clk,
  input  logic [$clog2(p_num_entries)-1:0] read_addr,
  output logic [p_data_nbits-1:0]          read_data,
  input  logic                             write_en,
  input  logic [$clog2(p_num_entries)-1:0] write_addr,
  input  logic [p_data_nbits-1:0]          write_data
);

  logic [p_data_nbits-1:0] mem_q [p_num_entries];

  assign read_data = mem_q[read_addr];

  always_ff @(posedge clk) begin
    if (write_en) mem_q[write_addr] <= write_data;
  end

endmodule

// File: rtl/branch_trace_driver.sv
// Replays a stored (PC, taken) trace against a branch predictor and scores it.
//   state | meaning
//   IDLE  | waiting for start; pred_pc and update strobe held at 0
//   PRED  | present trace[idx].pc, capture the predictor's answer
//   UPD   | same PC, issue the update, bump the statistics counters
module branch_trace_driver
  import branch_pkg::*;
#(
  parameter int TRACE_DEPTH = 1024,
  parameter int CNT_NBITS   = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           trace_wr_en,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_wr_addr,
  input  logic [31:0]                    trace_wr_pc,
  input  logic                           trace_wr_taken,
  input  logic [$clog2(TRACE_DEPTH):0]   num_branches,
  input  logic [CNT_NBITS-1:0]           warmup,
  input  logic                           start,
  input  logic                           abort,
  output logic [31:0]                    pred_pc,
  input  logic                           prediction,
  output logic                           pred_update_en,
  output logic                           pred_update_val,
  output logic                           busy,
  output logic                           done,
  output logic [CNT_NBITS-1:0]           branch_count,
  output logic [CNT_NBITS-1:0]           mispredict_count
);

  localparam int A = $clog2(TRACE_DEPTH);
  localparam logic [A:0] N_MAX = (A+1)'(TRACE_DEPTH);

  drv_state_e           state_q, state_d;
  logic [A-1:0]         idx_q, idx_d;
  logic [A:0]           n_q, n_d;
  logic [CNT_NBITS-1:0] warmup_q, warmup_d;
  logic                 pred_q, pred_d;
  logic [CNT_NBITS-1:0] branch_count_q, branch_count_d;
  logic [CNT_NBITS-1:0] mispredict_count_q, mispredict_count_d;
  logic                 done_q, done_d;

  trace_rec_t rd_rec, wr_rec;
  logic [A:0] n_clamp;
  logic       last_rec;

  assign wr_rec = '{pc: trace_wr_pc, taken: trace_wr_taken};

  vc_Regfile_1r1w #(
    .p_data_nbits  ($bits(trace_rec_t)),
    .p_num_entries (TRACE_DEPTH)
  ) trace_store (
    .clk        (clk),
    .read_addr  (idx_q),
    .read_data  (rd_rec),
    .write_en   (trace_wr_en && !busy),
    .write_addr (trace_wr_addr),
    .write_data (wr_rec)
  );

  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
  assign n_clamp          = (num_branches > N_MAX) ? N_MAX : num_branches;
  assign last_rec         = ({1'b0, idx_q} == n_q - (A+1)'(1));

  always_comb begin
    state_d            = state_q;
    idx_d              = idx_q;
    n_d                = n_q;
    warmup_d           = warmup_q;
    pred_d             = pred_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    done_d             = 1'b0;
    pred_pc            = '0;
    pred_update_en     = 1'b0;
    pred_update_val    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d                = n_clamp;
          warmup_d           = warmup;
          branch_count_d     = '0;
          mispredict_count_d = '0;
          idx_d              = '0;
          if (n_clamp == '0) done_d  = 1'b1;
          else               state_d = PRED;
        end
      end
      PRED: begin
        pred_pc = rd_rec.pc;
        pred_d  = prediction;
        state_d = abort ? IDLE : UPD;
      end
      UPD: begin
        pred_pc         = rd_rec.pc;
        pred_update_en  = 1'b1;
        pred_update_val = rd_rec.taken;
        branch_count_d  = CNT_NBITS'(sat_inc(64'(branch_count_q), CNT_NBITS));
        // Warmup compares against the count before this branch is added.
        if ((pred_q != rd_rec.taken) && (branch_count_q >= warmup_q))
          mispredict_count_d = CNT_NBITS'(sat_inc(64'(mispredict_count_q), CNT_NBITS));
        if (abort) begin
          state_d = IDLE;
        end else if (last_rec) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + A'(1);
          state_d = PRED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= IDLE;
      idx_q              <= '0;
      n_q                <= '0;
      warmup_q           <= '0;
      pred_q             <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      done_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      idx_q              <= idx_d;
      n_q                <= n_d;
      warmup_q           <= warmup_d;
      pred_q             <= pred_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      done_q             <= done_d;
    end
  end

endmodule

// File: tb/tb_branch_trace_driver.sv
// Randomized scoreboard bench for branch_trace_driver with a behavioural predictor
// (stub or gshare) and an abstract reference model of the accuracy counters.
module tb_branch_trace_driver;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int CNT   = 4;
  localparam int CMAX  = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          trace_wr_en;
  logic [AW-1:0] trace_wr_addr;
  logic [31:0]   trace_wr_pc;
  logic          trace_wr_taken;
  logic [AW:0]   num_branches;
  logic [CNT-1:0] warmup;
  logic          start;
  logic          abort;
  logic [31:0]   pred_pc;
  logic          prediction;
  logic          pred_update_en;
  logic          pred_update_val;
  logic          busy;
  logic          done;
  logic [CNT-1:0] branch_count;
  logic [CNT-1:0] mispredict_count;

  branch_trace_driver #(.TRACE_DEPTH(DEPTH), .CNT_NBITS(CNT)) dut (
    .clk              (clk),
    .reset            (reset),
    .trace_wr_en      (trace_wr_en),
    .trace_wr_addr    (trace_wr_addr),
    .trace_wr_pc      (trace_wr_pc),
    .trace_wr_taken   (trace_wr_taken),
    .num_branches     (num_branches),
    .warmup           (warmup),
    .start            (start),
    .abort            (abort),
    .pred_pc          (pred_pc),
    .prediction       (prediction),
    .pred_update_en   (pred_update_en),
    .pred_update_val  (pred_update_val),
    .busy             (busy),
    .done             (done),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc - start_cyc);
    end
  endtask

  // Shadow of what the trace store should hold.
  logic [31:0] trace_pc [DEPTH];
  logic        trace_tk [DEPTH];

  // Behavioural predictor: pmode 0 always predicts not-taken, pmode 1 is gshare.
  int         pmode = 0;
  logic       pclr;
  logic [1:0] ptab [16];
  logic [3:0] ghr;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic tk);
    if (tk) return (c == 2'd3) ? c : c + 2'd1;
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  assign prediction = (pmode == 1) ? ptab[pred_pc[5:2] ^ ghr][1] : 1'b0;

  always @(posedge clk) begin
    if (pclr) begin
      for (int i = 0; i < 16; i++) ptab[i] <= 2'b01;
      ghr <= '0;
    end else if (pred_update_en && pmode == 1) begin
      ptab[pred_pc[5:2] ^ ghr] <= ctr_next(ptab[pred_pc[5:2] ^ ghr], pred_update_val);
      ghr <= {ghr[2:0], pred_update_val};
    end
  end

  // Reference accuracy model over the first n_proc trace records.
  function automatic void ref_counts(input int n_proc, input int warm, input int mode,
                                     output int bc, output int mc);
    logic [1:0] t [16];
    logic [3:0] g;
    logic       p;
    for (int i = 0; i < 16; i++) t[i] = 2'b01;
    g = '0; bc = 0; mc = 0;
    for (int i = 0; i < n_proc; i++) begin
      p = (mode == 1) ? t[trace_pc[i][5:2] ^ g][1] : 1'b0;
      if (p != trace_tk[i] && bc >= warm) mc = (mc < CMAX) ? mc + 1 : mc;
      bc = (bc < CMAX) ? bc + 1 : bc;
      t[trace_pc[i][5:2] ^ g] = ctr_next(t[trace_pc[i][5:2] ^ g], trace_tk[i]);
      g = {g[2:0], trace_tk[i]};
    end
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    int          at;
  } upd_t;

  upd_t upd_q [$];
  int   done_q [$];
  upd_t mon_e;
  int   mon_d;

  // Monitor: every update strobe and done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (pred_update_en) begin
        if (upd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_update: pred_pc=0x%0h with no pending branch", pred_pc);
        end else begin
          mon_e = upd_q.pop_front();
          check("upd_pc", pred_pc, mon_e.pc);
          check("upd_val", pred_update_val, mon_e.taken);
          check("upd_cycle", cyc - start_cyc, mon_e.at);
        end
      end else begin
        check("upd_val_idle", pred_update_val, 0);
      end
      if (done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done high at cycle %0d", cyc - start_cyc);
        end else begin
          mon_d = done_q.pop_front();
          check("done_cycle", cyc - start_cyc, mon_d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input int addr, input logic [31:0] pc, input logic tk);
    trace_wr_en = 1'b1; trace_wr_addr = AW'(addr); trace_wr_pc = pc; trace_wr_taken = tk;
    tick();
    trace_wr_en = 1'b0;
    trace_pc[addr] = pc; trace_tk[addr] = tk;
  endtask

  task automatic prep(input int mode);
    pmode = mode; pclr = 1'b1;
    tick();
    pclr = 1'b0;
  endtask

  // abort_at: cycle (relative to start) in which abort is high, -1 for none.
  task automatic run(input int n_req, input int warm, input int abort_at, input bit noise);
    int n, proc, end_busy, exp_bc, exp_mc;
    bit exp_done;
    n = (n_req > DEPTH) ? DEPTH : n_req;
    if (abort_at >= 1 && abort_at <= 2 * n) begin
      end_busy = abort_at; exp_done = 0;
      proc = (abort_at % 2 == 1) ? (abort_at - 1) / 2 : abort_at / 2;
    end else begin
      end_busy = 2 * n; exp_done = 1; proc = n;
    end
    ref_counts(proc, warm, pmode, exp_bc, exp_mc);
    start_cyc = cyc;
    for (int i = 0; i < proc; i++) upd_q.push_back('{trace_pc[i], trace_tk[i], 2 * i + 2});
    if (exp_done) done_q.push_back(2 * n + 1);
    num_branches = (AW+1)'(n_req); warmup = CNT'(warm);
    start = 1'b1; abort = (abort_at == 0);
    for (int j = 1; j <= end_busy + 3; j++) begin
      tick();
      start = 1'b0; abort = (j == abort_at); trace_wr_en = 1'b0;
      if (noise && j < 2 * n - 1) begin
        start = ($urandom_range(3) == 0);
        if ($urandom_range(1) == 1) begin
          trace_wr_en = 1'b1; trace_wr_addr = AW'($urandom);
          trace_wr_pc = $urandom; trace_wr_taken = 1'($urandom);
        end
      end
      check("busy", busy, (j <= end_busy));
    end
    start = 1'b0; abort = 1'b0; trace_wr_en = 1'b0;
    check("branch_count", branch_count, exp_bc);
    check("mispredict_count", mispredict_count, exp_mc);
    check("pending_updates", upd_q.size(), 0);
    check("pending_done", done_q.size(), 0);
  endtask

  initial begin
    int rn, rw, ra;
    reset = 1'b1; trace_wr_en = 1'b0; trace_wr_addr = '0; trace_wr_pc = '0;
    trace_wr_taken = 1'b0; num_branches = '0; warmup = '0; start = 1'b0; abort = 1'b0;
    pclr = 1'b1;
    repeat (2) tick();
    check("rst_pred_pc", pred_pc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_upd_en", pred_update_en, 0);
    check("rst_upd_val", pred_update_val, 0);
    check("rst_branch_count", branch_count, 0);
    check("rst_mispredict_count", mispredict_count, 0);
    reset = 1'b0; pclr = 1'b0;
    tick();
    check("post_rst_upd_en", pred_update_en, 0);

    for (int i = 0; i < 4; i++) load(i, 32'h100 + 32'(4 * i), 1'b1);
    prep(0);
    run(4, 0, -1, 0);
    run(4, 2, -1, 0);
    run(0, 0, -1, 0);
    run(4, 0, 5, 0);
    run(0, 0, -1, 0);
    run(4, 0, 4, 0);
    run(4, 0, 0, 0);

    for (int i = 0; i < DEPTH; i++) load(i, 32'h200 + 32'(4 * i), 1'b1);
    run(63, 0, -1, 0);

    for (int i = 0; i < DEPTH; i++) load(i, 32'h300, (i % 2 == 0));
    prep(1);
    run(32, 0, -1, 1);

    repeat (8) begin
      for (int i = 0; i < DEPTH; i++)
        load(i, 32'h400 + 32'(4 * $urandom_range(3)), 1'($urandom));
      prep(int'($urandom_range(1)));
      rn = int'($urandom_range(40));
      rw = int'($urandom_range(CMAX));
      ra = (rn > 0 && $urandom_range(2) == 0) ? int'($urandom_range(2 * rn + 2, 1)) : -1;
      run(rn, rw, ra, (ra < 0) && ($urandom_range(1) == 1));
    end

    prep(0);
    start_cyc = cyc;
    upd_q.push_back('{trace_pc[0], trace_tk[0], 2});
    upd_q.push_back('{trace_pc[1], trace_tk[1], 4});
    num_branches = 6'd8; warmup = '0; start = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      start = 1'b0;
      if (j == 5) reset = 1'b1;
    end
    tick();
    reset = 1'b0;
    check("midrst_pred_pc", pred_pc, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_upd_en", pred_update_en, 0);
    check("midrst_upd_val", pred_update_val, 0);
    check("midrst_branch_count", branch_count, 0);
    check("midrst_mispredict_count", mispredict_count, 0);
    repeat (20) tick();
    check("midrst_pending_updates", upd_q.size(), 0);
    check("midrst_busy_later", busy, 0);

    run(8, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
